// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, fetch address, IF/ID register
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] PC_INCR   = 32'h1000_0000,
    parameter logic [31:0] BAD_INSTR = 32'h0FFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] mem_address,
    input  logic [31:0] mem_instruction,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_next,
    output logic        if_id_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic        bad_word;
    logic        flush;
    logic        capture;
    logic        halt_hit;
    logic        resume;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: one bubble out of IDLE, halt on sentinel, leave HALT only on redirect
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = FETCH;
            FETCH:   if (!branch_taken && !stall && bad_word) state_next = HALT;
            HALT:    if (branch_taken) state_next = FETCH;
            default: state_next = IDLE;
        endcase
    end

    // Control decode: redirect beats stall, stall beats halt detection, halt beats capture
    always_comb begin
        bad_word    = (mem_instruction == BAD_INSTR);
        flush       = (state == FETCH) && branch_taken;
        capture     = (state == FETCH) && !branch_taken && !stall && !bad_word;
        halt_hit    = (state == FETCH) && !branch_taken && !stall && bad_word;
        resume      = (state == HALT) && branch_taken;
        mem_address = pc;
    end

    // PC and IF/ID pipeline register update
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc            <= RESET_PC;
            if_id_instr   <= 32'h0;
            if_id_pc      <= 32'h0;
            if_id_pc_next <= 32'h0;
            if_id_valid   <= 1'b0;
            halted        <= 1'b0;
            fetch_count   <= 16'h0;
        end else begin
            // Redirect is honoured in every state, including the IDLE bubble
            if (branch_taken) begin
                pc <= branch_target;
            end else if (capture) begin
                pc <= pc + PC_INCR;
            end

            if (flush) begin
                if_id_valid <= 1'b0;
                if_id_instr <= 32'h0;
            end else if (capture) begin
                if_id_instr   <= mem_instruction;
                if_id_pc      <= pc;
                if_id_pc_next <= pc + PC_INCR;
                if_id_valid   <= 1'b1;
                fetch_count   <= fetch_count + 16'd1;
            end else if (halt_hit) begin
                if_id_valid <= 1'b0;
            end

            if (halt_hit) begin
                halted <= 1'b1;
            end else if (resume) begin
                halted <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] mem_address;
    logic [31:0] mem_instruction;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_next;
    logic        if_id_valid;
    logic        halted;
    logic [15:0] fetch_count;

    int pass_cnt;
    int total_cnt;
    logic mem_ext;

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .mem_address     (mem_address),
        .mem_instruction (mem_instruction),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_pc_next   (if_id_pc_next),
        .if_id_valid     (if_id_valid),
        .halted          (halted),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word 0 = A00000AA, word k = k*0x10000011, others out of range
    always_comb begin
        case (mem_address[31:28])
            4'd0:    mem_instruction = 32'hA000_00AA;
            4'd1:    mem_instruction = 32'h1000_0011;
            4'd2:    mem_instruction = 32'h2000_0022;
            4'd3:    mem_instruction = 32'h3000_0033;
            4'd4:    mem_instruction = 32'h4000_0044;
            4'd5:    mem_instruction = 32'h5000_0055;
            4'd6:    mem_instruction = 32'h6000_0066;
            4'd7:    mem_instruction = 32'h7000_0077;
            4'd8:    mem_instruction = 32'h8000_0088;
            4'd9:    mem_instruction = 32'h9000_0099;
            4'd15:   mem_instruction = mem_ext ? 32'hF000_00FF : 32'h0FFF_FFFF;
            default: mem_instruction = 32'h0FFF_FFFF;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if (mem_address !== 32'h0) $display("FAIL reset_addr got %h exp %h", mem_address, 32'h0); else pass_cnt++;
        total_cnt++; if (if_id_instr !== 32'h0) $display("FAIL reset_instr got %h exp %h", if_id_instr, 32'h0); else pass_cnt++;
        total_cnt++; if (if_id_pc_next !== 32'h0) $display("FAIL reset_pc_next got %h exp %h", if_id_pc_next, 32'h0); else pass_cnt++;
        total_cnt++; if ({if_id_valid, halted} !== 2'b00) $display("FAIL reset_flags got %b exp %b", {if_id_valid, halted}, 2'b00); else pass_cnt++;
        total_cnt++; if (fetch_count !== 16'h0) $display("FAIL reset_count got %0d exp %0d", fetch_count, 0); else pass_cnt++;
    endtask

    task automatic test_sequential();
        step();
        total_cnt++; if (if_id_valid !== 1'b0) $display("FAIL seq_bubble_valid got %b exp %b", if_id_valid, 1'b0); else pass_cnt++;
        step();
        total_cnt++; if (if_id_instr !== 32'hA000_00AA) $display("FAIL seq_instr0 got %h exp %h", if_id_instr, 32'hA000_00AA); else pass_cnt++;
        total_cnt++; if (if_id_pc !== 32'h0) $display("FAIL seq_pc0 got %h exp %h", if_id_pc, 32'h0); else pass_cnt++;
        total_cnt++; if (if_id_pc_next !== 32'h1000_0000) $display("FAIL seq_pc_next0 got %h exp %h", if_id_pc_next, 32'h1000_0000); else pass_cnt++;
        total_cnt++; if (if_id_valid !== 1'b1) $display("FAIL seq_valid0 got %b exp %b", if_id_valid, 1'b1); else pass_cnt++;
        total_cnt++; if (fetch_count !== 16'd1) $display("FAIL seq_count0 got %0d exp %0d", fetch_count, 1); else pass_cnt++;
        step();
        total_cnt++; if (if_id_instr !== 32'h1000_0011) $display("FAIL seq_instr1 got %h exp %h", if_id_instr, 32'h1000_0011); else pass_cnt++;
        total_cnt++; if (if_id_pc !== 32'h1000_0000) $display("FAIL seq_pc1 got %h exp %h", if_id_pc, 32'h1000_0000); else pass_cnt++;
        total_cnt++; if (fetch_count !== 16'd2) $display("FAIL seq_count1 got %0d exp %0d", fetch_count, 2); else pass_cnt++;
        total_cnt++; if (mem_address !== 32'h2000_0000) $display("FAIL seq_addr got %h exp %h", mem_address, 32'h2000_0000); else pass_cnt++;
    endtask

    task automatic test_stall();
        step();
        total_cnt++; if (if_id_instr !== 32'h2000_0022) $display("FAIL stall_pre_instr got %h exp %h", if_id_instr, 32'h2000_0022); else pass_cnt++;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++; if (if_id_instr !== 32'h2000_0022) $display("FAIL stall_instr[%0d] got %h exp %h", i, if_id_instr, 32'h2000_0022); else pass_cnt++;
            total_cnt++; if (if_id_pc !== 32'h2000_0000) $display("FAIL stall_pc[%0d] got %h exp %h", i, if_id_pc, 32'h2000_0000); else pass_cnt++;
            total_cnt++; if (mem_address !== 32'h3000_0000) $display("FAIL stall_addr[%0d] got %h exp %h", i, mem_address, 32'h3000_0000); else pass_cnt++;
            total_cnt++; if (fetch_count !== 16'd3) $display("FAIL stall_count[%0d] got %0d exp %0d", i, fetch_count, 3); else pass_cnt++;
        end
        stall = 1'b0;
        step();
        total_cnt++; if (if_id_instr !== 32'h3000_0033) $display("FAIL stall_post_instr got %h exp %h", if_id_instr, 32'h3000_0033); else pass_cnt++;
        total_cnt++; if (fetch_count !== 16'd4) $display("FAIL stall_post_count got %0d exp %0d", fetch_count, 4); else pass_cnt++;
    endtask

    task automatic test_branch();
        do_reset();
        step(); step(); step();
        total_cnt++; if (mem_address !== 32'h2000_0000) $display("FAIL br_pre_addr got %h exp %h", mem_address, 32'h2000_0000); else pass_cnt++;
        branch_taken = 1'b1;
        branch_target = 32'h7000_0000;
        step();
        branch_taken = 1'b0;
        total_cnt++; if (if_id_valid !== 1'b0) $display("FAIL br_flush_valid got %b exp %b", if_id_valid, 1'b0); else pass_cnt++;
        total_cnt++; if (if_id_instr !== 32'h0) $display("FAIL br_flush_instr got %h exp %h", if_id_instr, 32'h0); else pass_cnt++;
        total_cnt++; if (mem_address !== 32'h7000_0000) $display("FAIL br_addr got %h exp %h", mem_address, 32'h7000_0000); else pass_cnt++;
        total_cnt++; if (fetch_count !== 16'd2) $display("FAIL br_count got %0d exp %0d", fetch_count, 2); else pass_cnt++;
        step();
        total_cnt++; if (if_id_instr !== 32'h7000_0077) $display("FAIL br_tgt_instr got %h exp %h", if_id_instr, 32'h7000_0077); else pass_cnt++;
        total_cnt++; if (if_id_pc !== 32'h7000_0000) $display("FAIL br_tgt_pc got %h exp %h", if_id_pc, 32'h7000_0000); else pass_cnt++;
        total_cnt++; if (if_id_valid !== 1'b1) $display("FAIL br_tgt_valid got %b exp %b", if_id_valid, 1'b1); else pass_cnt++;
    endtask

    task automatic test_branch_stall();
        branch_taken = 1'b1;
        stall = 1'b1;
        branch_target = 32'h1000_0000;
        step();
        branch_taken = 1'b0;
        stall = 1'b0;
        total_cnt++; if (mem_address !== 32'h1000_0000) $display("FAIL bs_addr got %h exp %h", mem_address, 32'h1000_0000); else pass_cnt++;
        total_cnt++; if (if_id_valid !== 1'b0) $display("FAIL bs_valid got %b exp %b", if_id_valid, 1'b0); else pass_cnt++;
        step();
        total_cnt++; if (if_id_instr !== 32'h1000_0011) $display("FAIL bs_instr got %h exp %h", if_id_instr, 32'h1000_0011); else pass_cnt++;
        total_cnt++; if (if_id_pc !== 32'h1000_0000) $display("FAIL bs_pc got %h exp %h", if_id_pc, 32'h1000_0000); else pass_cnt++;
    endtask

    task automatic test_halt();
        do_reset();
        for (int i = 0; i < 11; i++) step();
        total_cnt++; if (if_id_instr !== 32'h9000_0099) $display("FAIL halt_last_instr got %h exp %h", if_id_instr, 32'h9000_0099); else pass_cnt++;
        total_cnt++; if (mem_address !== 32'hA000_0000) $display("FAIL halt_pre_addr got %h exp %h", mem_address, 32'hA000_0000); else pass_cnt++;
        step();
        total_cnt++; if (halted !== 1'b1) $display("FAIL halt_flag got %b exp %b", halted, 1'b1); else pass_cnt++;
        total_cnt++; if (if_id_valid !== 1'b0) $display("FAIL halt_valid got %b exp %b", if_id_valid, 1'b0); else pass_cnt++;
        total_cnt++; if (fetch_count !== 16'd10) $display("FAIL halt_count got %0d exp %0d", fetch_count, 10); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            stall = i[0];
            step();
            total_cnt++; if (mem_address !== 32'hA000_0000) $display("FAIL halt_hold_addr[%0d] got %h exp %h", i, mem_address, 32'hA000_0000); else pass_cnt++;
            total_cnt++; if ({halted, if_id_valid} !== 2'b10) $display("FAIL halt_hold_flags[%0d] got %b exp %b", i, {halted, if_id_valid}, 2'b10); else pass_cnt++;
        end
        stall = 1'b0;
        branch_taken = 1'b1;
        branch_target = 32'h0;
        step();
        branch_taken = 1'b0;
        total_cnt++; if (halted !== 1'b0) $display("FAIL halt_resume_flag got %b exp %b", halted, 1'b0); else pass_cnt++;
        total_cnt++; if (mem_address !== 32'h0) $display("FAIL halt_resume_addr got %h exp %h", mem_address, 32'h0); else pass_cnt++;
        step();
        total_cnt++; if (if_id_instr !== 32'hA000_00AA) $display("FAIL halt_refetch got %h exp %h", if_id_instr, 32'hA000_00AA); else pass_cnt++;
        total_cnt++; if (fetch_count !== 16'd11) $display("FAIL halt_refetch_count got %0d exp %0d", fetch_count, 11); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) step();
        total_cnt++; if ({mem_address, if_id_valid} !== {32'h5000_0000, 1'b1}) $display("FAIL mid_pre got %h/%b exp %h/%b", mem_address, if_id_valid, 32'h5000_0000, 1'b1); else pass_cnt++;
        rst = 1'b0;
        step();
        rst = 1'b1;
        total_cnt++; if ({mem_address, if_id_instr, if_id_pc, if_id_pc_next} !== 128'h0) $display("FAIL mid_rst_words got %h %h %h %h exp 0", mem_address, if_id_instr, if_id_pc, if_id_pc_next); else pass_cnt++;
        total_cnt++; if ({if_id_valid, halted, fetch_count} !== 18'h0) $display("FAIL mid_rst_flags got %b %b %0d exp 0", if_id_valid, halted, fetch_count); else pass_cnt++;
        step();
        total_cnt++; if (if_id_valid !== 1'b0) $display("FAIL mid_bubble got %b exp %b", if_id_valid, 1'b0); else pass_cnt++;
        step();
        total_cnt++; if (if_id_instr !== 32'hA000_00AA) $display("FAIL mid_refetch got %h exp %h", if_id_instr, 32'hA000_00AA); else pass_cnt++;
    endtask

    task automatic test_idle_branch();
        do_reset();
        branch_taken = 1'b1;
        branch_target = 32'h3000_0000;
        step();
        branch_taken = 1'b0;
        total_cnt++; if (mem_address !== 32'h3000_0000) $display("FAIL idle_br_addr got %h exp %h", mem_address, 32'h3000_0000); else pass_cnt++;
        total_cnt++; if (if_id_valid !== 1'b0) $display("FAIL idle_br_valid got %b exp %b", if_id_valid, 1'b0); else pass_cnt++;
        step();
        total_cnt++; if (if_id_instr !== 32'h3000_0033) $display("FAIL idle_br_instr got %h exp %h", if_id_instr, 32'h3000_0033); else pass_cnt++;
    endtask

    task automatic test_pc_wrap();
        mem_ext = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'hF000_0000;
        step();
        branch_taken = 1'b0;
        step();
        total_cnt++; if (if_id_instr !== 32'hF000_00FF) $display("FAIL wrap_instr got %h exp %h", if_id_instr, 32'hF000_00FF); else pass_cnt++;
        total_cnt++; if (if_id_pc_next !== 32'h0) $display("FAIL wrap_pc_next got %h exp %h", if_id_pc_next, 32'h0); else pass_cnt++;
        total_cnt++; if (mem_address !== 32'h0) $display("FAIL wrap_addr got %h exp %h", mem_address, 32'h0); else pass_cnt++;
        step();
        total_cnt++; if (if_id_instr !== 32'hA000_00AA) $display("FAIL wrap_next got %h exp %h", if_id_instr, 32'hA000_00AA); else pass_cnt++;
        mem_ext = 1'b0;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        mem_ext = 1'b0;
        rst = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_branch_stall();
        test_halt();
        test_reset_mid();
        test_idle_branch();
        test_pc_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
